// File: rtl/serial_line_tx_pkg.sv
// Shared types and link constants for the serial clock/data transmitters.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } tx_state_t;

  localparam int TPR_LINE_LENGTH = 40;
  localparam int S_WORD_LENGTH   = 20;
  localparam int DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/serial_line_tx_if.sv
// Word handshake and serial-link signals of one serial_line_tx instance.
interface serial_line_tx_if
  import serial_link_pkg::*;
#(
  parameter int WORD_LENGTH = TPR_LINE_LENGTH
) ();

  logic [WORD_LENGTH-1:0] DATA_IN;
  logic                   VALID;
  logic                   READY;
  logic                   SER_CLK;
  logic                   SER_DATA;
  logic                   BUSY;
  logic                   DONE;

  modport master (
    output DATA_IN, VALID,
    input  READY, SER_CLK, SER_DATA, BUSY, DONE
  );

  modport slave (
    input  DATA_IN, VALID,
    output READY, SER_CLK, SER_DATA, BUSY, DONE
  );

endinterface

// File: rtl/serial_line_tx_bit_phase_timer.sv
// Serial-clock half-period divider: one-cycle phase_end every CLK_DIV cycles while run.
module bit_phase_timer
  import serial_link_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic phase_end
);

  localparam int                DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign phase_end = run && (div_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (restart || !run || phase_end) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_line_tx.sv
// Bit-serial link transmitter, bit 0 first, data captured on SER_CLK rise.
// SERIAL_TX_REPEAT_EN: re-send the last word from a hold register while idle.
module serial_line_tx
  import serial_link_pkg::*;
#(
  parameter int WORD_LENGTH = TPR_LINE_LENGTH,
  parameter int CLK_DIV     = DEFAULT_CLK_DIV
) (
  input  logic             CLK,
  input  logic             RST_N,
  serial_line_tx_if.slave  link
);

  localparam int               CNT_W    = $clog2(WORD_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

  tx_state_t              state, state_next;
  logic [WORD_LENGTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_next;
  logic                   done_q, done_next;
  logic                   start;
  logic                   busy;
  logic                   phase_end;

`ifdef SERIAL_TX_REPEAT_EN
  logic [WORD_LENGTH-1:0] hold_reg, hold_next;
  logic                   hold_valid, hold_valid_next;
`endif

  assign busy          = (state != IDLE);
  assign link.BUSY     = busy;
  assign link.READY    = !busy;
  assign link.SER_CLK  = (state == HIGH);
  assign link.SER_DATA = busy & shift_reg[0];
  assign link.DONE     = done_q;

  bit_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST_N),
    .restart   (start),
    .run       (busy),
    .phase_end (phase_end)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
    start        = 1'b0;
`ifdef SERIAL_TX_REPEAT_EN
    hold_next       = hold_reg;
    hold_valid_next = hold_valid;
`endif
    unique case (state)
      IDLE: begin
        if (link.VALID && !busy) begin
          start        = 1'b1;
          shift_next   = link.DATA_IN;
          bit_cnt_next = '0;
          state_next   = LOW;
`ifdef SERIAL_TX_REPEAT_EN
          hold_next       = link.DATA_IN;
          hold_valid_next = 1'b1;
`endif
        end
`ifdef SERIAL_TX_REPEAT_EN
        else if (hold_valid) begin
          start        = 1'b1;
          shift_next   = hold_reg;
          bit_cnt_next = '0;
          state_next   = LOW;
        end
`endif
      end
      LOW: begin
        if (phase_end) state_next = HIGH;
      end
      HIGH: begin
        if (phase_end) begin
          if (bit_cnt == LAST_BIT) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
            state_next   = LOW;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_REPEAT_EN
      hold_reg   <= '0;
      hold_valid <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      done_q    <= done_next;
`ifdef SERIAL_TX_REPEAT_EN
      hold_reg   <= hold_next;
      hold_valid <= hold_valid_next;
`endif
    end
  end

endmodule

// File: doc/serial_line_tx.md
# serial_line_tx

Serial-link transmitter for the two-wire clock/data links that feed the board (typewriter line `TPR_CLK`/`TPR_DATA`, staticisor switches `S_CLK`/`S_DATA`). It takes a parallel word through a valid/ready handshake and emits it bit-serially, bit 0 first. Each data bit is set up while the serial clock is low and captured by the far-end receiver on the serial-clock rising edge. One instance per link sits on the panel/host side and drives the receiver's shift-and-count logic.

## Interface
- `WORD_LENGTH`, default 40: bits per frame. Set to 40 for the typewriter link, 20 for the switch link. Must equal the receiver's count.
- `CLK_DIV`, default 4: `CLK` cycles per serial-clock half-period. Must be ≥1.
- `CLK` input 1: system clock. All logic is on its rising edge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `DATA_IN` input `WORD_LENGTH`: word to send. Bit 0 is transmitted first.
- `VALID` input 1: `DATA_IN` is offered.
- `READY` output 1: transmitter accepts a word this cycle.
- `SER_CLK` output 1: serial clock to the link.
- `SER_DATA` output 1: serial data to the link.
- `BUSY` output 1: a frame is in progress.
- `DONE` output 1: one-cycle pulse at end of frame.

## Operation
- FSM states: `IDLE`, `LOW`, `HIGH`.
- `IDLE`:
  - `READY`=1, `SER_CLK`=0.
  - On `VALID && READY`, latch `DATA_IN` into the shift register, clear the bit counter, and go to `LOW`.
  - If `VALID` is low, stay in `IDLE`.
- `LOW`:
  - `SER_DATA` = shift register bit 0.
  - `SER_CLK`=0 for `CLK_DIV` cycles, then go to `HIGH`.
- `HIGH`:
  - `SER_CLK`=1 for `CLK_DIV` cycles. `SER_DATA` is held.
  - At the end of the phase: if the bit counter equals `WORD_LENGTH-1`, go to `IDLE` and pulse `DONE`.
  - Otherwise shift right by one, increment the bit counter, and go to `LOW`.
- `BUSY` = (state ≠ `IDLE`). `READY` = `!BUSY`.
- `DATA_IN` is ignored while `BUSY`. The shift register is the only copy of the frame in flight.
- Every accepted frame emits exactly `WORD_LENGTH` rising edges. No partial frames exist except on reset, because the receiver has no framing and relies on the count alone.
- Widths:
  - Bit counter: `$clog2(WORD_LENGTH)+1` bits.
  - Divider: `$clog2(CLK_DIV)+1` bits, counts 0..`CLK_DIV-1`, and wraps on phase change.
- Reset, including mid-frame:
  - State goes to `IDLE`. Shift register and all counters clear.
  - Outputs: `SER_CLK`=0, `SER_DATA`=0, `READY`=1, `BUSY`=0, `DONE`=0.
  - An aborted frame leaves the receiver misaligned. The system resets both ends together.

## Timing
- The first `SER_DATA` bit is valid the cycle after acceptance, with `SER_CLK` low.
- Bit period = 2·`CLK_DIV` cycles. The rising edge occurs `CLK_DIV` cycles after the data change, giving `CLK_DIV` cycles of setup and `CLK_DIV` cycles of hold.
- Frame length: acceptance to `DONE` = `WORD_LENGTH`·2·`CLK_DIV` cycles. With defaults this is 320.
- `DONE` is asserted in the first `IDLE` cycle, and `READY` is high in that same cycle.
- Back-to-back: a word accepted on the `DONE` cycle starts `LOW` on the next cycle. The minimum inter-frame gap is 1 cycle with `SER_CLK` low.

## Configuration
- `SERIAL_TX_REPEAT_EN` defined:
  - In `IDLE` with `VALID`=0, after at least one frame has been sent since reset, the last word is re-transmitted automatically from a hold register. This gives a display-style refresh.
  - A `VALID` word in the same `IDLE` cycle takes priority and replaces the hold register.
  - `DONE` pulses on repeat frames as well.
- `SERIAL_TX_REPEAT_EN` undefined: no hold register. The transmitter stays in `IDLE` until `VALID`.

## Structure
- Package `serial_link_pkg` holds:
  - The state enum `tx_state_t` {`IDLE`, `LOW`, `HIGH`}.
  - Link-length constants `TPR_LINE_LENGTH`=40 and `S_WORD_LENGTH`=20.
  - `DEFAULT_CLK_DIV`=4.
- One sub-module, `bit_phase_timer`: the `CLK_DIV` divider producing a one-cycle `phase_end` tick. It is restarted on acceptance.

## Test plan
- Defaults, `DATA_IN`=40'h00000_00001 accepted:
  - `SER_DATA`=1 on rising edge 1 and 0 on edges 2–40.
  - Exactly 40 `SER_CLK` rising edges.
  - `DONE` arrives 320 cycles after acceptance.
- Model receiver with `WORD_LENGTH`=20, three back-to-back words (20'hABCDE, 20'h12345, 20'hFFFFF):
  - The receiver reconstructs all three exactly.
  - Gap between frames is 1 cycle.
- `VALID` held high with `DATA_IN` changing mid-frame:
  - `READY`=0 throughout the frame.
  - Transmitted bits match the word latched at acceptance.
- `RST_N` pulled low at bit 17:
  - Outputs go to reset values asynchronously, without waiting for `CLK`.
  - After release, the next frame starts from bit 0.
- `CLK_DIV`=1:
  - Bit period is 2 cycles.
  - Data is stable across every `SER_CLK` rising edge.
- `SERIAL_TX_REPEAT_EN` defined, one word 40'h5_5555_5555 sent and then `VALID` held 0:
  - Identical frames repeat continuously with a 1-cycle gap and one `DONE` pulse per frame.
  - A new `VALID` word is sent on the next `IDLE` cycle.
